// File: rtl/shape_compute_engine.sv
// Shape arithmetic engine: decodes a CTRL shape/operation command, computes perimeter, area or a
// shape predicate (multiplies via a serial shift-add unit) and returns it over valid/ready.
module shape_compute_engine #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_shape,
    input  logic [6:0]        cmd_operation,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [DATA_W-1:0] cmd_c,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_data,
    output logic              res_error,
    output logic              res_overflow,
    output logic              busy
);

    localparam int ACC_W = 2 * DATA_W + COEF_W;
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [COEF_W-1:0] PI_Q8     = COEF_W'(804);
    localparam logic [COEF_W-1:0] TWO_PI_Q8 = COEF_W'(1608);

    localparam logic [2:0] SHAPE_CIRCLE    = 3'd1;
    localparam logic [2:0] SHAPE_RECTANGLE = 3'd2;
    localparam logic [2:0] SHAPE_TRIANGLE  = 3'd3;

    localparam logic [6:0] OP_PERIMETER      = 7'd1;
    localparam logic [6:0] OP_AREA           = 7'd2;
    localparam logic [6:0] OP_IS_SQUARE      = 7'd3;
    localparam logic [6:0] OP_IS_EQUILATERAL = 7'd4;
    localparam logic [6:0] OP_IS_ISOSCELES   = 7'd5;

    localparam logic [CNT_W-1:0] MUL1_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] MUL2_LAST = CNT_W'(COEF_W - 1);

    typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               circ_q, circ_area_q;
    logic [ACC_W-1:0]   acc, mcand, acc_next;
    logic [DATA_W-1:0]  mplier;

    logic               dec_err, dec_mul, dec_circ, dec_circ_area;
    logic [31:0]        dec_data;
    logic [DATA_W-1:0]  dec_mcand, dec_mplier;

    // Drop the Q.8 fraction; anything left above bit 31 saturates.
    function automatic logic [32:0] scale_sat(input logic [ACC_W-1:0] prod);
        logic [ACC_W-1:0] sh;
        sh = prod >> 8;
        if (|sh[ACC_W-1:32])
            scale_sat = {1'b1, 32'hFFFF_FFFF};
        else
            scale_sat = {1'b0, sh[31:0]};
    endfunction

    // Command decode: single-pass results, error detection and multiplier operand selection.
    always_comb begin
        dec_err       = 1'b0;
        dec_mul       = 1'b0;
        dec_circ      = 1'b0;
        dec_circ_area = 1'b0;
        dec_data      = '0;
        dec_mcand     = '0;
        dec_mplier    = '0;
        case (cmd_shape)
            SHAPE_CIRCLE: begin
                dec_err = (cmd_a == '0);
                case (cmd_operation)
                    OP_PERIMETER: begin
                        dec_mul    = 1'b1;
                        dec_circ   = 1'b1;
                        dec_mcand  = DATA_W'(TWO_PI_Q8);
                        dec_mplier = cmd_a;
                    end
                    OP_AREA: begin
                        dec_mul       = 1'b1;
                        dec_circ      = 1'b1;
                        dec_circ_area = 1'b1;
                        dec_mcand     = cmd_a;
                        dec_mplier    = cmd_a;
                    end
                    default: dec_err = 1'b1;
                endcase
            end
            SHAPE_RECTANGLE: begin
                dec_err = (cmd_a == '0) || (cmd_b == '0);
                case (cmd_operation)
                    OP_PERIMETER: dec_data = (32'(cmd_a) + 32'(cmd_b)) << 1;
                    OP_AREA: begin
                        dec_mul    = 1'b1;
                        dec_mcand  = cmd_a;
                        dec_mplier = cmd_b;
                    end
                    OP_IS_SQUARE: dec_data = {31'b0, cmd_a == cmd_b};
                    default:      dec_err  = 1'b1;
                endcase
            end
            SHAPE_TRIANGLE: begin
                dec_err = (cmd_a == '0) || (cmd_b == '0) || (cmd_c == '0);
                case (cmd_operation)
                    OP_PERIMETER:      dec_data = 32'(cmd_a) + 32'(cmd_b) + 32'(cmd_c);
                    OP_IS_EQUILATERAL: dec_data = {31'b0, (cmd_a == cmd_b) && (cmd_b == cmd_c)};
                    OP_IS_ISOSCELES:   dec_data = {31'b0, (cmd_a == cmd_b) || (cmd_b == cmd_c) ||
                                                          (cmd_a == cmd_c)};
                    default:           dec_err  = 1'b1;
                endcase
            end
            default: dec_err = 1'b1;
        endcase
        if (dec_err) begin
            dec_mul       = 1'b0;
            dec_circ      = 1'b0;
            dec_circ_area = 1'b0;
            dec_data      = '0;
        end
    end

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (cmd_valid) state_nx = dec_mul ? MUL1 : DONE;
            MUL1: if (cnt == MUL1_LAST) state_nx = circ_area_q ? MUL2 : DONE;
            MUL2: if (cnt == MUL2_LAST) state_nx = DONE;
            DONE: if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            circ_q       <= 1'b0;
            circ_area_q  <= 1'b0;
            res_data     <= '0;
            res_error    <= 1'b0;
            res_overflow <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cnt         <= '0;
                        circ_q      <= dec_circ;
                        circ_area_q <= dec_circ_area;
                        if (!dec_mul) begin
                            res_data     <= dec_data;
                            res_error    <= dec_err;
                            res_overflow <= 1'b0;
                        end
                    end
                end
                MUL1: begin
                    cnt <= (cnt == MUL1_LAST) ? '0 : cnt + 1'b1;
                    if (cnt == MUL1_LAST && !circ_area_q) begin
                        res_error <= 1'b0;
                        if (circ_q) begin
                            {res_overflow, res_data} <= scale_sat(acc_next);
                        end else begin
                            res_overflow <= 1'b0;
                            res_data     <= acc_next[31:0];
                        end
                    end
                end
                MUL2: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == MUL2_LAST) begin
                        res_error                <= 1'b0;
                        {res_overflow, res_data} <= scale_sat(acc_next);
                    end
                end
                default: ;
            endcase
        end
    end

    // Serial multiplier: one multiplier bit per cycle, LSB first; second pass multiplies by pi.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    acc    <= '0;
                    mcand  <= ACC_W'(dec_mcand);
                    mplier <= dec_mplier;
                end
            end
            MUL1: begin
                if (cnt == MUL1_LAST && circ_area_q) begin
                    acc    <= '0;
                    mcand  <= ACC_W'(acc_next[2*DATA_W-1:0]);
                    mplier <= DATA_W'(PI_Q8);
                end else begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end
            end
            MUL2: begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shape_compute_engine.sv
// Testbench for shape_compute_engine: directed scenarios plus random commands against a
// plain-arithmetic reference model.
module tb_shape_compute_engine;

    localparam logic [2:0] CIRCLE     = 3'd1;
    localparam logic [2:0] RECTANGLE  = 3'd2;
    localparam logic [2:0] TRIANGLE   = 3'd3;
    localparam logic [2:0] KEEP_SHAPE = 3'd7;
    localparam logic [6:0] PERIMETER      = 7'd1;
    localparam logic [6:0] AREA           = 7'd2;
    localparam logic [6:0] IS_SQUARE      = 7'd3;
    localparam logic [6:0] IS_EQUILATERAL = 7'd4;
    localparam logic [6:0] IS_ISOSCELES   = 7'd5;
    localparam logic [6:0] KEEP_OPERATION = 7'h7F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_shape = '0;
    logic [6:0]  cmd_operation = '0;
    logic [15:0] cmd_a = '0, cmd_b = '0, cmd_c = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_error, res_overflow, busy;

    int errors = 0;
    int checks = 0;

    shape_compute_engine dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_shape(cmd_shape), .cmd_operation(cmd_operation),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_error(res_error), .res_overflow(res_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [2:0] s, input logic [6:0] o,
                                  input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                                  output logic [31:0] d, output logic e, output logic v,
                                  output int lat);
        longint unsigned la, lb, lc, p;
        la = 64'(a); lb = 64'(b); lc = 64'(c);
        d = '0; e = 1'b0; v = 1'b0; lat = 1;
        if (s == CIRCLE && o == PERIMETER && a != 0) begin
            p = (la * 1608) >> 8; d = p[31:0]; lat = 17;
        end else if (s == CIRCLE && o == AREA && a != 0) begin
            p = (la * la * 804) >> 8; lat = 28;
            if (p > 64'hFFFF_FFFF) begin d = 32'hFFFF_FFFF; v = 1'b1; end
            else d = p[31:0];
        end else if (s == RECTANGLE && a != 0 && b != 0 && o == PERIMETER) begin
            p = 2 * (la + lb); d = p[31:0];
        end else if (s == RECTANGLE && a != 0 && b != 0 && o == AREA) begin
            p = la * lb; d = p[31:0]; lat = 17;
        end else if (s == RECTANGLE && a != 0 && b != 0 && o == IS_SQUARE) begin
            d = (a == b) ? 32'd1 : 32'd0;
        end else if (s == TRIANGLE && a != 0 && b != 0 && c != 0 && o == PERIMETER) begin
            p = la + lb + lc; d = p[31:0];
        end else if (s == TRIANGLE && a != 0 && b != 0 && c != 0 && o == IS_EQUILATERAL) begin
            d = (a == b && b == c) ? 32'd1 : 32'd0;
        end else if (s == TRIANGLE && a != 0 && b != 0 && c != 0 && o == IS_ISOSCELES) begin
            d = (a == b || b == c || a == c) ? 32'd1 : 32'd0;
        end else begin
            e = 1'b1;
        end
    endfunction

    // Issues one command, measures accept-to-valid latency, captures the result and pops it.
    task automatic run_cmd(input logic [2:0] s, input logic [6:0] o,
                           input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                           output logic [31:0] d, output logic e, output logic v,
                           output int lat, output bit to);
        int w;
        to = 1'b0; lat = 0; d = '0; e = 1'b0; v = 1'b0;
        cmd_shape = s; cmd_operation = o; cmd_a = a; cmd_b = b; cmd_c = c;
        cmd_valid = 1'b1; res_ready = 1'b0;
        w = 0;
        while (!cmd_ready && w < 100) begin @(posedge clk); #1; w++; end
        if (!cmd_ready) begin to = 1'b1; cmd_valid = 1'b0; return; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_a = 16'($urandom); cmd_b = 16'($urandom); cmd_c = 16'($urandom);
        cmd_shape = 3'($urandom); cmd_operation = 7'($urandom);
        lat = 1;
        while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!res_valid) begin to = 1'b1; return; end
        d = res_data; e = res_error; v = res_overflow;
        res_ready = 1'b1; @(posedge clk); #1; res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL reset_res_data got %0h want 0", res_data); end
        checks++; if (res_error !== 1'b0 || res_overflow !== 1'b0) begin
            errors++; $display("FAIL reset_flags got err=%b ovf=%b want 0/0", res_error, res_overflow); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rect_area();
        logic [31:0] d; logic e, v; int lat; bit to;
        run_cmd(RECTANGLE, AREA, 16'd300, 16'd500, 16'd0, d, e, v, lat, to);
        checks++; if (to || d !== 32'd150000) begin errors++; $display("FAIL rect_area_data got %0d want 150000", d); end
        checks++; if (lat != 17) begin errors++; $display("FAIL rect_area_latency got %0d want 17", lat); end
        checks++; if (e !== 1'b0 || v !== 1'b0) begin errors++; $display("FAIL rect_area_flags got err=%b ovf=%b want 0/0", e, v); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rect_area_ready_after_pop got %b want 1", cmd_ready); end
    endtask

    task automatic test_circle_area();
        logic [31:0] d; logic e, v; int lat; bit to;
        run_cmd(CIRCLE, AREA, 16'd10, 16'd0, 16'd0, d, e, v, lat, to);
        checks++; if (to || d !== 32'd314) begin errors++; $display("FAIL circle_area_data got %0d want 314", d); end
        checks++; if (lat != 28) begin errors++; $display("FAIL circle_area_latency got %0d want 28", lat); end
        run_cmd(CIRCLE, AREA, 16'd65535, 16'd0, 16'd0, d, e, v, lat, to);
        checks++; if (to || d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL circle_area_sat_data got %0h want ffffffff", d); end
        checks++; if (v !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL circle_area_sat_flags got ovf=%b err=%b want 1/0", v, e); end
        run_cmd(CIRCLE, PERIMETER, 16'd100, 16'd0, 16'd0, d, e, v, lat, to);
        checks++; if (to || d !== 32'd628 || lat != 17) begin
            errors++; $display("FAIL circle_perimeter got data=%0d lat=%0d want 628/17", d, lat); end
    endtask

    task automatic test_triangle();
        logic [31:0] d; logic e, v; int lat; bit to;
        run_cmd(TRIANGLE, IS_ISOSCELES, 16'd7, 16'd7, 16'd7, d, e, v, lat, to);
        checks++; if (to || d !== 32'd1 || lat != 1) begin errors++; $display("FAIL tri_iso_777 got data=%0d lat=%0d want 1/1", d, lat); end
        run_cmd(TRIANGLE, IS_ISOSCELES, 16'd3, 16'd4, 16'd5, d, e, v, lat, to);
        checks++; if (to || d !== 32'd0 || lat != 1) begin errors++; $display("FAIL tri_iso_345 got data=%0d lat=%0d want 0/1", d, lat); end
        run_cmd(TRIANGLE, PERIMETER, 16'd3, 16'd4, 16'd5, d, e, v, lat, to);
        checks++; if (to || d !== 32'd12 || lat != 1) begin errors++; $display("FAIL tri_perim got data=%0d lat=%0d want 12/1", d, lat); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e, v; int lat; bit to;
        run_cmd(TRIANGLE, AREA, 16'd3, 16'd4, 16'd5, d, e, v, lat, to);
        checks++; if (to || e !== 1'b1 || d !== 32'd0 || lat != 1) begin
            errors++; $display("FAIL err_tri_area got err=%b data=%0d lat=%0d want 1/0/1", e, d, lat); end
        run_cmd(RECTANGLE, PERIMETER, 16'd5, 16'd0, 16'd0, d, e, v, lat, to);
        checks++; if (to || e !== 1'b1 || d !== 32'd0 || lat != 1) begin
            errors++; $display("FAIL err_rect_zero got err=%b data=%0d lat=%0d want 1/0/1", e, d, lat); end
        run_cmd(KEEP_SHAPE, PERIMETER, 16'd5, 16'd6, 16'd7, d, e, v, lat, to);
        checks++; if (to || e !== 1'b1 || d !== 32'd0 || lat != 1) begin
            errors++; $display("FAIL err_keep_shape got err=%b data=%0d lat=%0d want 1/0/1", e, d, lat); end
        run_cmd(CIRCLE, KEEP_OPERATION, 16'd5, 16'd6, 16'd7, d, e, v, lat, to);
        checks++; if (to || e !== 1'b1 || v !== 1'b0) begin
            errors++; $display("FAIL err_keep_op got err=%b ovf=%b want 1/0", e, v); end
    endtask

    task automatic test_backpressure();
        int bad;
        cmd_shape = RECTANGLE; cmd_operation = PERIMETER; cmd_a = 16'd5; cmd_b = 16'd6; cmd_c = 16'd0;
        cmd_valid = 1'b1; res_ready = 1'b0;
        @(posedge clk); #1;
        cmd_a = 16'd1; cmd_b = 16'd1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b1 || res_data !== 32'd22 || cmd_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL backpressure_hold bad_cycles=%0d want 0 (data=%0d)", bad, res_data); end
        res_ready = 1'b1; @(posedge clk); #1; res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL backpressure_pop got valid=%b ready=%b want 0/1", res_valid, cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++; if (res_valid !== 1'b1 || res_data !== 32'd4) begin
            errors++; $display("FAIL backpressure_second got valid=%b data=%0d want 1/4", res_valid, res_data); end
        res_ready = 1'b1; @(posedge clk); #1; res_ready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d; logic e, v; int lat; bit to; bit stale;
        cmd_shape = RECTANGLE; cmd_operation = AREA; cmd_a = 16'd300; cmd_b = 16'd500;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL midflight_reset got busy=%b ready=%b valid=%b want 0/1/0", busy, cmd_ready, res_valid); end
        rst = 1'b0;
        stale = 1'b0;
        repeat (30) begin @(posedge clk); #1; if (res_valid !== 1'b0) stale = 1'b1; end
        checks++; if (stale) begin errors++; $display("FAIL midflight_stale got res_valid=1 want 0"); end
        run_cmd(RECTANGLE, PERIMETER, 16'd5, 16'd6, 16'd0, d, e, v, lat, to);
        checks++; if (to || d !== 32'd22 || e !== 1'b0) begin errors++; $display("FAIL midflight_recover got data=%0d err=%b want 22/0", d, e); end
    endtask

    task automatic test_random();
        logic [2:0]  shapes [9] = '{CIRCLE, RECTANGLE, TRIANGLE, CIRCLE, RECTANGLE, TRIANGLE, 3'd0, KEEP_SHAPE, 3'd5};
        logic [6:0]  ops [9] = '{PERIMETER, AREA, IS_SQUARE, IS_EQUILATERAL, IS_ISOSCELES,
                                  PERIMETER, AREA, KEEP_OPERATION, 7'd0};
        logic [2:0]  s; logic [6:0] o; logic [15:0] a, b, c;
        logic [31:0] d, md; logic e, v, me, mv; int lat, mlat; bit to;
        for (int n = 0; n < 60; n++) begin
            s = shapes[$urandom_range(0, 8)];
            o = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 1) == 0) begin
                a = 16'($urandom_range(0, 3)); b = 16'($urandom_range(0, 3)); c = 16'($urandom_range(0, 3));
            end else begin
                a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
                if ($urandom_range(0, 3) == 0) b = a;
                if ($urandom_range(0, 3) == 0) c = a;
            end
            model(s, o, a, b, c, md, me, mv, mlat);
            run_cmd(s, o, a, b, c, d, e, v, lat, to);
            checks++;
            if (to || d !== md || e !== me || v !== mv || lat != mlat || (e && v)) begin
                errors++;
                $display("FAIL random[%0d] s=%0d o=%0d a=%0d b=%0d c=%0d got d=%0d e=%b v=%b lat=%0d want d=%0d e=%b v=%b lat=%0d",
                         n, s, o, a, b, c, d, e, v, lat, md, me, mv, mlat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rect_area();
        test_circle_area();
        test_triangle();
        test_errors();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shape_compute_engine.md
# shape_compute_engine

Multi-cycle arithmetic engine directly downstream of the shape processor's CTRL SFR. On each accepted command it latches the shape and operation fields from CTRL and up to three unsigned dimension operands. It computes perimeter, area, or a shape predicate with an iterative shift-add multiplier, then returns the result over a valid/ready handshake. The shape processor top drives `cmd_shape` and `cmd_operation` straight from `ctrl_sfr` and issues a command per software "go" request.

## Interface
- `PI_Q8`, 804: π in unsigned Q.8 (3.140625).
- `TWO_PI_Q8`, 1608: 2π in unsigned Q.8.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  engine can accept; high only in IDLE.
- `cmd_shape`  in  3  shape code (CIRCLE, RECTANGLE, TRIANGLE; shape_processor_modeling encodings).
- `cmd_operation`  in  7  operation code (PERIMETER, AREA, IS_SQUARE, IS_EQUILATERAL, IS_ISOSCELES).
- `cmd_a`, `cmd_b`, `cmd_c`  in  16 each  dimensions: radius is `a`; rectangle uses `a`,`b`; triangle uses `a`,`b`,`c`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  32  result.
- `res_error`  out  1  command rejected.
- `res_overflow`  out  1  result saturated.
- `busy`  out  1  high in any state other than IDLE.

## Operation
**Reset and handshake**
- Reset values: `cmd_ready`=1, `busy`=0, `res_valid`=0, `res_data`=0, `res_error`=0, `res_overflow`=0; FSM enters IDLE.
- Accept occurs on a cycle with `cmd_valid && cmd_ready`. On accept, all `cmd_*` inputs are captured into internal registers; later input changes have no effect.

**FSM states:** IDLE, MUL1, MUL2, DONE.
- IDLE → DONE on accept of a 1-pass command.
- IDLE → MUL1 on accept of RECTANGLE/AREA, CIRCLE/PERIMETER or CIRCLE/AREA.
- MUL1 runs exactly 16 iterations, one multiplier bit per cycle, LSB first. It then goes to MUL2 for CIRCLE/AREA and to DONE otherwise.
- MUL2 runs exactly 11 iterations over the bits of `PI_Q8`, then goes to DONE.
- DONE holds `res_*` stable until `res_valid && res_ready`, then returns to IDLE.

**Legal combinations** (any other combination is an error)
- CIRCLE: PERIMETER, AREA.
- RECTANGLE: PERIMETER, AREA, IS_SQUARE.
- TRIANGLE: PERIMETER, IS_EQUILATERAL, IS_ISOSCELES.

**Results**
- RECTANGLE/PERIMETER: 2·(a+b), 1 pass.
- RECTANGLE/AREA: a·b, via MUL1.
- IS_SQUARE: 1 if a==b, else 0, 1 pass.
- CIRCLE/PERIMETER: (a·`TWO_PI_Q8`)>>8, truncated, via MUL1.
- CIRCLE/AREA: ((a·a)·`PI_Q8`)>>8, truncated, via MUL1 then MUL2. Intermediate width is 43 bits. A nonzero result above bit 31 saturates to 0xFFFF_FFFF and sets `res_overflow`.
- TRIANGLE/PERIMETER: a+b+c, 1 pass.
- IS_EQUILATERAL: 1 if a==b==c, else 0, 1 pass.
- IS_ISOSCELES: 1 if any two operands are equal (equilateral counts), else 0, 1 pass.

**Errors**
- An error is any of: a reserved shape; a reserved operation; a KEEP_SHAPE or KEEP_OPERATION code; an illegal combination; or a zero value in any operand the operation uses.
- Response: go to DONE in 1 cycle with `res_error`=1 and `res_data`=0. No multiply is performed.
- `res_error` and `res_overflow` are never both 1.

## Timing
- Accept at edge N:
  - 1-pass and error commands: `res_valid`=1 from edge N+1.
  - MUL1-only commands: `res_valid`=1 from edge N+17.
  - CIRCLE/AREA: `res_valid`=1 from edge N+28.
- Result consumed at edge M: `cmd_ready`=1 from edge M+1. There is no accept in the same cycle as a result pop, so the minimum issue interval is 2 cycles.
- `res_ready` while `res_valid`=0 is ignored.
- `cmd_valid` while busy is ignored and not queued. The upstream holds the command until `cmd_ready`.
- `rst` asserted mid-computation: immediate return to reset values and the in-flight command is discarded. Nothing is produced after release until a new accept.

## Test plan
- RECTANGLE/AREA, a=300, b=500, `res_ready`=1 → `res_data`=150000, `res_valid` 17 cycles after accept, `res_error`=0.
- CIRCLE/AREA, a=10 → `res_data`=314 (100·804>>8), latency 28. Then CIRCLE/AREA, a=65535 → `res_data`=0xFFFF_FFFF, `res_overflow`=1.
- TRIANGLE/IS_ISOSCELES, (7,7,7) → 1; (3,4,5) → 0; TRIANGLE/PERIMETER (3,4,5) → 12. Each has latency 1.
- TRIANGLE/AREA → `res_error`=1, `res_data`=0, latency 1. Same response for RECTANGLE/PERIMETER with b=0, and for a KEEP_SHAPE command.
- Backpressure: `res_ready`=0 for 10 cycles after RECTANGLE/PERIMETER (5,6). `res_data` must hold 22, with `cmd_ready`=0 and a second `cmd_valid` ignored throughout. The second command is accepted only after the pop.
- Assert `rst` 5 cycles into a RECTANGLE/AREA → next edge shows `busy`=0, `cmd_ready`=1, `res_valid`=0. No stale result appears afterwards.
